ahb_param_slave: RTL and testbench

AHB_PARAM_SLAVE -- requirements
Module: ahb_param_slave

---
 rtl/ahb_param_slave_if.sv | 23 ++
 rtl/ahb_param_slave.sv | 123 ++++++++++++
 tb/tb_ahb_param_slave.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_param_slave_if.sv
// AHB-Lite slave-side signal bundle with master and slave views.
interface ahb_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport ahb_s (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport ahb_m (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_param_slave.sv
// Parameterised AHB-Lite memory slave with programmable wait states and
// two-cycle ERROR responses for out-of-range, oversize or misaligned transfers.
module ahb_param_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] IDLE_RDATA  = 32'hdeadbeef
) (
    input logic   HCLK,
    input logic   HRESET,
    ahb_if.ahb_s  ahbsif
);

    localparam int unsigned IW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] SPAN    = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state, state_nxt;
    logic [3:0]    wcnt;
    logic [IW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic [31:0]   mem [MEM_WORDS];

    logic [31:0] offset;
    logic        in_range, misaligned, bad, accept, addr_open;
    logic        ready_o, resp_o;
    logic [31:0] rdata_o;
    logic [3:0]  be;

    always_comb begin
        offset     = ahbsif.HADDR - BASE_ADDR;
        in_range   = (ahbsif.HADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        misaligned = ((ahbsif.HSIZE == 3'b001) && ahbsif.HADDR[0]) ||
                     ((ahbsif.HSIZE == 3'b010) && (ahbsif.HADDR[1:0] != 2'b00));
        bad        = !in_range || (ahbsif.HSIZE > 3'b010) || misaligned;
        accept     = ahbsif.HSEL && ahbsif.HREADY && (ahbsif.HTRANS inside {2'b10, 2'b11});
    end

    always_comb begin
        state_nxt = state;
        addr_open = 1'b0;
        ready_o   = 1'b1;
        resp_o    = 1'b0;
        rdata_o   = IDLE_RDATA;
        case (state)
            S_IDLE: addr_open = 1'b1;
            S_WAIT: begin
                ready_o = 1'b0;
                if (wcnt == '0) state_nxt = S_DATA;
            end
            S_DATA: begin
                addr_open = 1'b1;
                if (!write_q) rdata_o = mem[idx_q];
            end
            S_ERR1: begin
                ready_o   = 1'b0;
                resp_o    = 1'b1;
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                addr_open = 1'b1;
                resp_o    = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Every state that completes a beat also samples the next address phase.
        if (addr_open) begin
            if (!accept)              state_nxt = S_IDLE;
            else if (bad)             state_nxt = S_ERR1;
            else if (WAIT_STATES > 0) state_nxt = S_WAIT;
            else                      state_nxt = S_DATA;
        end
    end

    assign ahbsif.HREADYOUT = ready_o;
    assign ahbsif.HRESP     = resp_o;
    assign ahbsif.HRDATA    = rdata_o;

    // The latched address is kept as word index plus byte lane.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (addr_open && accept) begin
                idx_q   <= offset[IW+1:2];
                lane_q  <= ahbsif.HADDR[1:0];
                size_q  <= ahbsif.HSIZE;
                write_q <= ahbsif.HWRITE;
                wcnt    <= WS_LOAD;
            end else if ((state == S_WAIT) && (wcnt != '0)) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    always_comb begin
        be = '0;
        case (size_q)
            3'b000:  be[lane_q] = 1'b1;
            3'b001:  be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && (state == S_DATA) && write_q) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= ahbsif.HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_param_slave.sv
// Two slaves (zero-wait at 0x0, three-wait 16-word at 0x1000) on one AHB bus,
// checked every cycle against a transaction-level response/memory model.
module tb_ahb_param_slave;

    localparam logic [31:0] IDLE_A = 32'hdeadbeef;
    localparam logic [31:0] IDLE_B = 32'h0bad_cafe;
    localparam logic [31:0] BASE_B = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_if ifa ();
    ahb_if ifb ();

    logic        sel0, sel1, hwrite, lo0, lo1, sys_rdy;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    int          dp = 0;

    assign sys_rdy = (dp == 0) ? ifa.HREADYOUT : ifb.HREADYOUT;

    assign ifa.HSEL = sel0;   assign ifb.HSEL = sel1;
    assign ifa.HADDR = haddr; assign ifb.HADDR = haddr;
    assign ifa.HTRANS = htrans; assign ifb.HTRANS = htrans;
    assign ifa.HWRITE = hwrite; assign ifb.HWRITE = hwrite;
    assign ifa.HSIZE = hsize; assign ifb.HSIZE = hsize;
    assign ifa.HWDATA = hwdata; assign ifb.HWDATA = hwdata;
    assign ifa.HREADY = sys_rdy & ~lo0;
    assign ifb.HREADY = sys_rdy & ~lo1;

    ahb_param_slave #(.BASE_ADDR(32'h0), .MEM_WORDS(1024), .WAIT_STATES(0), .IDLE_RDATA(IDLE_A))
        dut_a (.HCLK(clk), .HRESET(rst), .ahbsif(ifa));
    ahb_param_slave #(.BASE_ADDR(BASE_B), .MEM_WORDS(16), .WAIT_STATES(3), .IDLE_RDATA(IDLE_B))
        dut_b (.HCLK(clk), .HRESET(rst), .ahbsif(ifb));

    int n_err = 0;
    int n_chk = 0;
    bit cmp_en = 0;

    typedef struct {
        bit          rdy;
        bit          rsp;
        bit          rd;
        bit          wr;
        int          idx;
        logic [3:0]  be;
        logic [31:0] wd;
    } beat_t;

    beat_t       q0[$];
    beat_t       q1[$];
    logic [31:0] mm [2][16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic beat_t mk(bit rdy, bit rsp, bit rd, bit wr, int idx, logic [3:0] be, logic [31:0] wd);
        beat_t e;
        e.rdy = rdy; e.rsp = rsp; e.rd = rd; e.wr = wr; e.idx = idx; e.be = be; e.wd = wd;
        return e;
    endfunction

    task automatic push(input int t, input beat_t e);
        if (t == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Expected per-cycle responses of one accepted transfer, from the address map rules.
    task automatic model_push(input int t, input bit wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [31:0] wd);
        longint base  = (t == 0) ? 0 : longint'(BASE_B);
        longint words = (t == 0) ? 1024 : 16;
        int     ws    = (t == 0) ? 0 : 3;
        longint a     = longint'(addr);
        int     sh    = int'(a % 4);
        logic [3:0] be;
        bit err;
        err = (a < base) || (a >= base + 4 * words) || (size > 3'd2) ||
              (size == 3'd1 && (a % 2) != 0) || (size == 3'd2 && (a % 4) != 0);
        if (err) begin
            push(t, mk(0, 1, 0, 0, 0, 4'h0, 32'h0));
            push(t, mk(1, 1, 0, 0, 0, 4'h0, 32'h0));
        end else begin
            for (int k = 0; k < ws; k++) push(t, mk(0, 0, 0, 0, 0, 4'h0, 32'h0));
            if (size == 3'd0)      be = 4'(1 << sh);
            else if (size == 3'd1) be = 4'(3 << sh);
            else                   be = 4'hF;
            push(t, mk(1, 0, !wr, wr, int'((a - base) / 4), be, wd));
        end
    endtask

    task automatic cmp(input int t, input logic rdy, input logic rsp, input logic [31:0] rdat);
        beat_t e;
        logic [31:0] xr;
        e = mk(1, 0, 0, 0, 0, 4'h0, 32'h0);
        if (t == 0) begin
            if (q0.size() > 0) e = q0.pop_front();
        end else begin
            if (q1.size() > 0) e = q1.pop_front();
        end
        xr = e.rd ? mm[t][e.idx] : ((t == 0) ? IDLE_A : IDLE_B);
        check((t == 0) ? "cycle_a" : "cycle_b", {30'h0, rdy, rsp, rdat}, {30'h0, e.rdy, e.rsp, xr});
        if (e.wr) begin
            for (int b = 0; b < 4; b++)
                if (e.be[b]) mm[t][e.idx][8*b +: 8] = e.wd[8*b +: 8];
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, ifa.HREADYOUT, ifa.HRESP, ifa.HRDATA);
            cmp(1, ifb.HREADYOUT, ifb.HRESP, ifb.HRDATA);
        end
    end

    function automatic logic [33:0] smp(input int t);
        return (t == 0) ? {ifa.HREADYOUT, ifa.HRESP, ifa.HRDATA}
                        : {ifb.HREADYOUT, ifb.HRESP, ifb.HRDATA};
    endfunction

    task automatic go_idle();
        sel0 = 0; sel1 = 0; htrans = 2'b00; lo0 = 0; lo1 = 0;
    endtask

    // Issues an address phase and returns just after the edge that accepted it.
    task automatic xfer(input int t, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wd);
        int  n = 0;
        logic rdy;
        sel0 = (t == 0); sel1 = (t == 1); lo0 = 0; lo1 = 0;
        htrans = $urandom_range(0, 1) ? 2'b11 : 2'b10;
        haddr = addr; hwrite = wr; hsize = size;
        forever begin
            @(negedge clk); rdy = sys_rdy;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 40) break;
        end
        if (rdy) begin
            model_push(t, wr, addr, size, wd);
            dp = t;
            hwdata = wd;
        end else begin
            check("xfer_timeout", 64'(n), 64'h0);
        end
        go_idle();
    endtask

    task automatic noise(input int t, input int kind);
        case (kind)
            0: begin sel0 = (t == 0); sel1 = (t == 1); htrans = 2'b00; end
            1: begin sel0 = (t == 0); sel1 = (t == 1); htrans = 2'b01; end
            2: begin sel0 = 0; sel1 = 0; htrans = 2'b10; end
            default: begin
                sel0 = (t == 0); sel1 = (t == 1); htrans = 2'b10;
                lo0 = (t == 0); lo1 = (t == 1);
            end
        endcase
        haddr = (t == 0) ? 32'h0 : BASE_B;
        hwrite = 1; hsize = 3'd2;
        @(posedge clk); #1;
        go_idle();
    endtask

    task automatic wait_data(input int t, output int c, output logic [33:0] o);
        c = 0;
        @(negedge clk); o = smp(t);
        while (!o[33] && c < 20) begin
            c++;
            @(negedge clk); o = smp(t);
        end
        @(posedge clk); #1;
    endtask

    int          c, t, r;
    logic [33:0] o;
    logic [31:0] a, base;
    logic [2:0]  sz;

    initial begin
        go_idle();
        hwrite = 0; haddr = '0; hsize = '0; hwdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0; cmp_en = 1;
        @(negedge clk);
        check("reset_a", 64'(smp(0)), 64'({2'b10, IDLE_A}));
        check("reset_b", 64'(smp(1)), 64'({2'b10, IDLE_B}));
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            xfer(0, 1, 32'(4 * i), 3'd2, $urandom);
            xfer(1, 1, BASE_B + 32'(4 * i), 3'd2, $urandom);
        end

        xfer(0, 1, 32'h10, 3'd2, 32'hCAFEF00D);
        xfer(0, 0, 32'h10, 3'd2, 32'h0);
        wait_data(0, c, o);
        check("b2b_waits", 64'(c), 64'd0);
        check("b2b_rdata", 64'(o), 64'({2'b10, 32'hCAFEF00D}));

        xfer(1, 0, BASE_B + 32'h4, 3'd2, 32'h0);
        wait_data(1, c, o);
        check("ws3_count", 64'(c), 64'd3);
        check("ws3_data", 64'(o[33:32]), 64'h2);

        xfer(0, 1, 32'h20, 3'd2, 32'h11223344);
        xfer(0, 1, 32'h21, 3'd0, 32'h0000AA00);
        xfer(0, 1, 32'h22, 3'd1, 32'hBBBB0000);
        xfer(0, 0, 32'h20, 3'd2, 32'h0);
        wait_data(0, c, o);
        check("lanes_rdata", 64'(o), 64'({2'b10, 32'hBBBBAA44}));

        xfer(1, 1, BASE_B + 32'h40, 3'd2, 32'hFFFFFFFF);
        @(negedge clk); check("err_wr_1", 64'(smp(1)), 64'({2'b01, IDLE_B})); @(posedge clk); #1;
        @(negedge clk); check("err_wr_2", 64'(smp(1)), 64'({2'b11, IDLE_B})); @(posedge clk); #1;
        xfer(1, 0, BASE_B + 32'h2, 3'd2, 32'h0);
        @(negedge clk); check("err_rd_1", 64'(smp(1)), 64'({2'b01, IDLE_B})); @(posedge clk); #1;
        @(negedge clk); check("err_rd_2", 64'(smp(1)), 64'({2'b11, IDLE_B})); @(posedge clk); #1;

        for (int k = 0; k < 4; k++) begin
            noise(0, k);
            @(negedge clk); check("ignored_a", 64'(smp(0)), 64'({2'b10, IDLE_A})); @(posedge clk); #1;
        end

        xfer(1, 1, BASE_B + 32'h8, 3'd2, 32'h0BADF00D);
        xfer(1, 1, BASE_B + 32'h8, 3'd2, 32'h12345678);
        rst = 1;
        @(posedge clk); #1;
        q0.delete(); q1.delete();
        rst = 0;
        @(negedge clk); check("rst_mid_idle", 64'(smp(1)), 64'({2'b10, IDLE_B})); @(posedge clk); #1;
        xfer(1, 0, BASE_B + 32'h8, 3'd2, 32'h0);
        wait_data(1, c, o);
        check("rst_mid_mem", 64'(o), 64'({2'b10, 32'h0BADF00D}));

        for (int i = 0; i < 400; i++) begin
            t = $urandom_range(0, 1);
            base = (t == 1) ? BASE_B : 32'h0;
            r = $urandom_range(0, 9);
            if (r == 0)      a = ((t == 1) ? BASE_B + 32'h40 : 32'h1000) + 32'($urandom_range(0, 7));
            else if (r == 1) a = base - 32'd4;
            else             a = base + 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            xfer(t, 1'($urandom_range(0, 1)), a, sz, $urandom);
            if ($urandom_range(0, 3) == 0) noise($urandom_range(0, 1), $urandom_range(0, 3));
        end

        repeat (8) @(posedge clk);
        #1 check("drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
